parity_gen_chk_core: RTL and testbench
======================================

# parity_gen_chk_core

Registered 8-bit even/odd parity generator and checker for byte-wide datapaths. Each accepted input byte is passed through unchanged with a freshly generated parity bit. The byte's received parity bit is checked against the data and the result is flagged. It sits between a byte source (e.g. a UART/link receiver) and its consumer. An optional saturating error counter supports link-quality monitoring.

## Interface
Parameters:
- WIDTH, 8, data width in bits (must be ≥ 1).
- ODD, 0, parity sense: 0 = even parity, 1 = odd parity.
- CNT_W, 8, width of the error counter (used only when the counter is compiled in).

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  qualifies data_in/parity_in for the current cycle.
- data_in  input  WIDTH  received data word.
- parity_in  input  1  received parity bit accompanying data_in.
- out_valid  output  1  data_out/parity_out/error valid this cycle.
- data_out  output  WIDTH  registered copy of data_in.
- parity_out  output  1  generated parity bit for data_out.
- error  output  1  received word failed the parity check.
- err_count  output  CNT_W  saturating count of errored words (PARITY_GEN_CHK_ERR_CNT_EN only).

## Operation
- Reduction: p = XOR of all data_in bits.
- Generation:
  - even mode: parity_out = p;
  - odd mode: parity_out = ~p.
  - The total number of ones in {data_out, parity_out} is therefore even (even mode) or odd (odd mode).
- Check:
  - even mode: error = p ^ parity_in;
  - odd mode: error = ~(p ^ parity_in).
- Pass-through: data_out = data_in, with no modification or correction.
- Registers update only when in_valid = 1; otherwise data_out/parity_out/error hold their last values.
- No backpressure: every in_valid cycle is accepted.
- err_count increments by 1 on each accepted word with a failing check, and saturates at all-ones (no wrap).

## Timing
- Latency 1 cycle: inputs sampled at edge N appear on the outputs after edge N; out_valid = registered in_valid.
- Throughput: one word per cycle; back-to-back in_valid is supported.
- Reset (asynchronous assert, synchronous-safe release): out_valid = 0, data_out = 0, error = 0, err_count = 0.
  - parity_out resets to 0 in even mode and 1 in odd mode, consistent with data_out = 0.
- Reset asserted mid-stream clears all state immediately. The word presented in the reset-release cycle is sampled normally at the first rising edge after rst_n goes high.
- in_valid = 0 cycle: out_valid drops to 0 on the next edge and the other outputs hold.

## Configuration
- Macro PARITY_GEN_CHK_ERR_CNT_EN.
  - Defined: err_count port and the saturating counter are present.
  - Undefined: the port and counter are absent; all other behaviour is identical.

## Structure
- Shared package parity_pkg:
  - constants PARITY_EVEN = 0 and PARITY_ODD = 1;
  - default WIDTH (8);
  - a parity-function helper usable by other blocks.
- One sub-module, parity_tree: a combinational WIDTH-bit XOR reduction that outputs p.
  - It is instantiated once and shared by the generator and the checker.
- Top level holds the output registers, the generate/check muxing on ODD, and the conditional counter.

## Test plan
- Even mode, in_valid = 1, data_in = 8'h55, parity_in = 0 -> next cycle data_out = 8'h55, parity_out = 0, error = 0, out_valid = 1.
- Even mode, data_in = 8'h07, parity_in = 0 -> parity_out = 1, error = 1; with data_in = 8'h07, parity_in = 1 -> error = 0.
- Odd mode (ODD = 1), data_in = 8'hF0, parity_in = 0 -> parity_out = 1, error = 1; with data_in = 8'hF0, parity_in = 1 -> error = 0.
- Stream 8'hAA/p0, 8'h0F/p1, 8'h01/p0 back-to-back, then in_valid = 0 -> errors 0, 1, 1 on consecutive cycles, then out_valid = 0 with outputs held at 8'h01/1/1.
- With the counter compiled in and CNT_W = 2, drive 5 errored words -> err_count reads 1, 2, 3, 3, 3 (saturates).
- Assert rst_n = 0 mid-stream between edges -> outputs go to reset values immediately. After release, the first valid word (8'h55/p0) appears one cycle later with err_count = 0.

Source files
------------

// File: rtl/parity_gen_chk_core_pkg.sv
// Shared parity constants and helper for the parity generator/checker slice.
// Optional error counter is selected by the PARITY_GEN_CHK_ERR_CNT_EN macro.
package parity_pkg;

    localparam int PARITY_EVEN      = 0;
    localparam int PARITY_ODD       = 1;
    localparam int PARITY_DEF_WIDTH = 8;

    // Parity of up to 64 bits; narrower words are zero-extended, which does not change the result.
    function automatic logic parity_of(input logic [63:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/parity_gen_chk_core_if.sv
// Byte-stream bus between a source, the parity core and its consumer.
// err_count exists only when PARITY_GEN_CHK_ERR_CNT_EN is defined.
interface parity_gen_chk_core_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
);

    logic             in_valid;
    logic [WIDTH-1:0] data_in;
    logic             parity_in;
    logic             out_valid;
    logic [WIDTH-1:0] data_out;
    logic             parity_out;
    logic             error;
`ifdef PARITY_GEN_CHK_ERR_CNT_EN
    logic [CNT_W-1:0] err_count;
`endif

    if (WIDTH < 1 || CNT_W < 1) begin : g_param_chk
        $error("parity_gen_chk_core_if: WIDTH and CNT_W must be >= 1");
    end

    modport master (
        output in_valid,
        output data_in,
        output parity_in,
        input  out_valid,
        input  data_out,
        input  parity_out,
`ifdef PARITY_GEN_CHK_ERR_CNT_EN
        input  err_count,
`endif
        input  error
    );

    modport slave (
        input  in_valid,
        input  data_in,
        input  parity_in,
        output out_valid,
        output data_out,
        output parity_out,
`ifdef PARITY_GEN_CHK_ERR_CNT_EN
        output err_count,
`endif
        output error
    );

endinterface

// File: rtl/parity_gen_chk_core_tree.sv
// Combinational XOR reduction shared by the parity generator and checker.
module parity_tree #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] data,
    output logic             p
);

    assign p = ^data;

endmodule

// File: rtl/parity_gen_chk_core.sv
// Registered even/odd parity generator and checker with one-cycle latency.
// Define PARITY_GEN_CHK_ERR_CNT_EN to add the saturating error counter.
module parity_gen_chk_core
    import parity_pkg::*;
#(
    parameter int WIDTH = PARITY_DEF_WIDTH,
    parameter int ODD   = PARITY_EVEN,
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    parity_gen_chk_core_if.slave bus
);

    localparam logic ODD_BIT = (ODD != PARITY_EVEN);

    if (WIDTH < 1 || CNT_W < 1) begin : g_param_chk
        $error("parity_gen_chk_core: WIDTH and CNT_W must be >= 1");
    end

    logic             p_p0;
    logic             par_p0;
    logic             err_p0;

    logic             vld_p1;
    logic [WIDTH-1:0] data_p1;
    logic             par_p1;
    logic             err_p1;

    parity_tree #(
        .WIDTH (WIDTH)
    ) u_tree (
        .data (bus.data_in),
        .p    (p_p0)
    );

    // Stage p0: the generated bit already carries the sense, so the check
    // in both modes reduces to comparing it with the received bit.
    assign par_p0 = p_p0 ^ ODD_BIT;
    assign err_p0 = par_p0 ^ bus.parity_in;

    // Stage p1: output registers, held while in_valid is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1  <= 1'b0;
            data_p1 <= '0;
            par_p1  <= ODD_BIT;
            err_p1  <= 1'b0;
        end else begin
            vld_p1 <= bus.in_valid;
            if (bus.in_valid) begin
                data_p1 <= bus.data_in;
                par_p1  <= par_p0;
                err_p1  <= err_p0;
            end
        end
    end

    assign bus.out_valid  = vld_p1;
    assign bus.data_out   = data_p1;
    assign bus.parity_out = par_p1;
    assign bus.error      = err_p1;

`ifdef PARITY_GEN_CHK_ERR_CNT_EN
    logic [CNT_W-1:0] cnt_p1;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        return (&cnt) ? cnt : cnt + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_p1 <= '0;
        end else if (bus.in_valid && err_p0) begin
            cnt_p1 <= sat_inc(cnt_p1);
        end
    end

    assign bus.err_count = cnt_p1;
`endif

endmodule

// File: tb/tb_parity_gen_chk_core.sv
// Directed bench for parity_gen_chk_core: one even-mode and one odd-mode instance.
module tb_parity_gen_chk_core;

    localparam int W  = 8;
    localparam int CW = 2;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    parity_gen_chk_core_if #(.WIDTH(W), .CNT_W(CW)) bus_e ();
    parity_gen_chk_core_if #(.WIDTH(W), .CNT_W(CW)) bus_o ();

    parity_gen_chk_core #(.WIDTH(W), .ODD(0), .CNT_W(CW)) dut_e (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_e)
    );

    parity_gen_chk_core #(.WIDTH(W), .ODD(1), .CNT_W(CW)) dut_o (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_e(input string tag, input logic v, input logic [7:0] d,
                           input logic par, input logic err);
        check({tag, ".e.vld"}, 32'(bus_e.out_valid), 32'(v));
        check({tag, ".e.data"}, 32'(bus_e.data_out), 32'(d));
        check({tag, ".e.par"}, 32'(bus_e.parity_out), 32'(par));
        check({tag, ".e.err"}, 32'(bus_e.error), 32'(err));
    endtask

    task automatic check_o(input string tag, input logic v, input logic [7:0] d,
                           input logic par, input logic err);
        check({tag, ".o.vld"}, 32'(bus_o.out_valid), 32'(v));
        check({tag, ".o.data"}, 32'(bus_o.data_out), 32'(d));
        check({tag, ".o.par"}, 32'(bus_o.parity_out), 32'(par));
        check({tag, ".o.err"}, 32'(bus_o.error), 32'(err));
    endtask

    task automatic check_cnt(input string tag, input logic [CW-1:0] exp);
`ifdef PARITY_GEN_CHK_ERR_CNT_EN
        check({tag, ".e.cnt"}, 32'(bus_e.err_count), 32'(exp));
`else
        if (exp === 'x) check({tag, ".cnt.unused"}, 32'(0), 32'(1));
`endif
    endtask

    // Drive both instances at the falling edge, then settle just past the rising edge.
    task automatic step(input logic ve, input logic [7:0] de, input logic pe,
                        input logic vo, input logic [7:0] dO, input logic po);
        @(negedge clk);
        bus_e.in_valid = ve; bus_e.data_in = de; bus_e.parity_in = pe;
        bus_o.in_valid = vo; bus_o.data_in = dO; bus_o.parity_in = po;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n = 1'b0;
        bus_e.in_valid = 1'b0; bus_e.data_in = '0; bus_e.parity_in = 1'b0;
        bus_o.in_valid = 1'b0; bus_o.data_in = '0; bus_o.parity_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_e("reset", 1'b0, 8'h00, 1'b0, 1'b0);
        check_o("reset", 1'b0, 8'h00, 1'b1, 1'b0);
        check_cnt("reset", 2'd0);

        @(negedge clk);
        rst_n = 1'b1;

        step(1'b1, 8'h55, 1'b0, 1'b0, 8'h00, 1'b0);
        check_e("e55p0", 1'b1, 8'h55, 1'b0, 1'b0);
        check_o("o_idle", 1'b0, 8'h00, 1'b1, 1'b0);
        check_cnt("e55p0", 2'd0);

        step(1'b1, 8'h07, 1'b0, 1'b1, 8'hF0, 1'b0);
        check_e("e07p0", 1'b1, 8'h07, 1'b1, 1'b1);
        check_o("oF0p0", 1'b1, 8'hF0, 1'b1, 1'b1);
        check_cnt("e07p0", 2'd1);

        step(1'b1, 8'h07, 1'b1, 1'b1, 8'hF0, 1'b1);
        check_e("e07p1", 1'b1, 8'h07, 1'b1, 1'b0);
        check_o("oF0p1", 1'b1, 8'hF0, 1'b1, 1'b0);
        check_cnt("e07p1", 2'd1);

        step(1'b1, 8'hAA, 1'b0, 1'b1, 8'h01, 1'b1);
        check_e("sAA", 1'b1, 8'hAA, 1'b0, 1'b0);
        check_o("o01p1", 1'b1, 8'h01, 1'b0, 1'b1);
        step(1'b1, 8'h0F, 1'b1, 1'b0, 8'h00, 1'b0);
        check_e("s0F", 1'b1, 8'h0F, 1'b0, 1'b1);
        check_o("o_hold", 1'b0, 8'h01, 1'b0, 1'b1);
        check_cnt("s0F", 2'd2);
        step(1'b1, 8'h01, 1'b0, 1'b0, 8'h00, 1'b0);
        check_e("s01", 1'b1, 8'h01, 1'b1, 1'b1);
        check_cnt("s01", 2'd3);
        step(1'b0, 8'hFF, 1'b0, 1'b0, 8'h00, 1'b0);
        check_e("s_idle", 1'b0, 8'h01, 1'b1, 1'b1);
        check_cnt("s_idle", 2'd3);

        // Asynchronous reset landing between clock edges mid-stream.
        step(1'b1, 8'h07, 1'b0, 1'b1, 8'h3C, 1'b1);
        check_e("pre_rst", 1'b1, 8'h07, 1'b1, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_e("mid_rst", 1'b0, 8'h00, 1'b0, 1'b0);
        check_o("mid_rst", 1'b0, 8'h00, 1'b1, 1'b0);
        check_cnt("mid_rst", 2'd0);

        @(negedge clk);
        bus_e.in_valid = 1'b1; bus_e.data_in = 8'h55; bus_e.parity_in = 1'b0;
        bus_o.in_valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_e("rel55", 1'b1, 8'h55, 1'b0, 1'b0);
        check_cnt("rel55", 2'd0);

        step(1'b1, 8'h01, 1'b0, 1'b0, 8'h00, 1'b0);
        check_e("sat1", 1'b1, 8'h01, 1'b1, 1'b1);
        check_cnt("sat1", 2'd1);
        step(1'b1, 8'h03, 1'b1, 1'b0, 8'h00, 1'b0);
        check_e("sat2", 1'b1, 8'h03, 1'b0, 1'b1);
        check_cnt("sat2", 2'd2);
        step(1'b1, 8'h80, 1'b0, 1'b0, 8'h00, 1'b0);
        check_e("sat3", 1'b1, 8'h80, 1'b1, 1'b1);
        check_cnt("sat3", 2'd3);
        step(1'b1, 8'hFE, 1'b0, 1'b0, 8'h00, 1'b0);
        check_e("sat4", 1'b1, 8'hFE, 1'b1, 1'b1);
        check_cnt("sat4", 2'd3);
        step(1'b1, 8'h07, 1'b0, 1'b0, 8'h00, 1'b0);
        check_e("sat5", 1'b1, 8'h07, 1'b1, 1'b1);
        check_cnt("sat5", 2'd3);
        step(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0);
        check_e("end_idle", 1'b0, 8'h07, 1'b1, 1'b1);
        check_cnt("end_idle", 2'd3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
